mc_mem_arbiter: RTL and testbench
=================================

# mc_mem_arbiter

Parametrised shared data-memory arbiter for the multi-core build. It replaces the single-core comm/processor selector in front of the DRAM, multiplexing one external communication port and `NUM_CORES` processor cores onto a single-port data memory. Core requests are handled by a registered, pipelined round-robin grant, sustaining one access per cycle. The block also aggregates the cores' end-of-process flags into a single done indication.

## Interface
- `NUM_CORES`, default 4: number of processor cores, 2..16.
- `DATA_W`, default 16: data word width.
- `ADDR_W`, default 16: data-memory address width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `status`  in  2  mode: 00 LOAD (comm writes), 01 RUN (cores), 10 READBACK (comm reads), 11 HALT.
- `com_data_in`  in  DATA_W  comm write data.
- `com_addr`  in  ADDR_W  comm address.
- `com_wr_en`  in  1  comm write strobe; honoured in LOAD only.
- `com_data_out`  out  DATA_W  DM read data to the comm port (DM_out pass-through).
- `core_req`  in  NUM_CORES  per-core access request; held until granted.
- `core_wr_en`  in  NUM_CORES  per-core write (1) or read (0).
- `core_addr`  in  NUM_CORES*ADDR_W  flattened addresses; core i at bits [i*ADDR_W +: ADDR_W].
- `core_wdata`  in  NUM_CORES*DATA_W  flattened write data.
- `core_done`  in  NUM_CORES  per-core end_process.
- `core_grant`  out  NUM_CORES  one-hot grant pulse.
- `core_rvalid`  out  NUM_CORES  one-hot read-data-valid pulse.
- `core_rdata`  out  DATA_W  shared read data (DM_out).
- `DM_addr`  out  ADDR_W  registered DRAM address.
- `DM_data_in`  out  DATA_W  registered DRAM write data.
- `DM_write_en`  out  1  registered DRAM write enable.
- `DM_out`  in  DATA_W  DRAM read data, one-cycle registered read.
- `end_process`  out  1  all cores done.

## Operation
- FSM states: COMM (status 00 or 10), RUN (status 01), HALT (status 11). The next state is a direct decode of `status` every cycle.
- COMM: each cycle, register `com_addr` into DM_addr and `com_data_in` into DM_data_in. DM_write_en ← `com_wr_en` only when status is 00, otherwise 0. No core grants in this state.
- RUN arbitration:
  - eligible = core_req & ~core_grant (a core granted this cycle is masked out, because it still holds req).
  - Round-robin winner is the first eligible index at or after `rr_ptr`, wrapping modulo NUM_CORES.
  - On a win: register the winner's addr/wdata/wr_en into DM_*, pulse its core_grant next cycle, and set rr_ptr ← winner+1 (wrapping NUM_CORES-1 → 0).
  - No eligible core: DM_write_en ← 0; DM_addr and DM_data_in hold.
- Read return: when a granted access is a read, `core_rvalid[winner]` pulses one cycle after the grant. A one-deep registered tag holds the winner index.
- Entering RUN from any other state: rr_ptr ← 0.
- Leaving RUN (mid-run status change):
  - No new grants are issued.
  - An access already registered still completes.
  - Its rvalid is still issued.
- HALT: DM_write_en ← 0; no grants; outputs hold.
- end_process: set when `&core_done` in RUN; sticky; cleared when status leaves RUN.
- Reset values: every registered output is 0, as are rr_ptr, the tag and the FSM state.
  - FSM state resets to COMM.
  - Cleared outputs: DM_addr, DM_data_in, DM_write_en, core_grant, core_rvalid, end_process.

## Timing
- Core access:
  - Edge t samples req. Cycle t+1: core_grant and DM_* valid; the DRAM writes/reads at edge t+1.
  - Cycle t+2: core_rvalid, with core_rdata = DM_out.
  - Read latency is 2 cycles from request sample.
- Throughput: one access per cycle with ≥2 requesters. A single continuous requester is granted every other cycle because of the grant mask.
- Comm: address sampled at edge t, write at edge t+1, read data on com_data_out in cycle t+2.
- Write data must be stable while req is high.

## Configuration
- `MC_ARB_FIXED_PRIORITY_EN`: when defined, the lowest eligible index always wins and rr_ptr is absent. When undefined (default), round-robin as above.

## Structure
- Package `mc_pkg`:
  - status encodings `ST_LOAD`, `ST_RUN`, `ST_READBACK`, `ST_HALT`;
  - FSM state typedef;
  - `MAX_CORES = 16`.
- Sub-module `rr_arbiter`: parametrised NUM_CORES, with inputs req/ptr and outputs one-hot grant/index. It contains the fixed-priority variant under the macro.

## Test plan
- Reset mid-RUN with a grant pending → all outputs 0 immediately; no rvalid afterwards.
- LOAD: write 0xA5A5 @0x0010 via comm, then READBACK @0x0010 → com_data_out = 0xA5A5 two cycles after the address.
- RUN, 4 cores requesting reads continuously → grant order 0,1,2,3,0…, one grant per cycle; each rvalid two cycles after the request sample.
- Core 2 write 0x1234 @0x0040, then core 0 read @0x0040 → core_rdata 0x1234 with core_rvalid[0].
- Status 01→11 with core 1 request registered → its rvalid still fires; no further grants.
- core_done goes to 4'b1111 one bit at a time → end_process rises the cycle after the last bit; clears when status → 00.

Source files
------------

// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : mc_pkg                                                   |
// | Purpose   : Shared types and constants for the multi-core data-      |
// |             memory arbiter (status encodings, FSM state type).       |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package mc_pkg;

  // Upper bound on the number of cores the arbiter is built for
  localparam int MAX_CORES = 16;

  // Mode encodings presented on the status input
  localparam logic [1:0] ST_LOAD     = 2'b00;
  localparam logic [1:0] ST_RUN      = 2'b01;
  localparam logic [1:0] ST_READBACK = 2'b10;
  localparam logic [1:0] ST_HALT     = 2'b11;

  // Arbiter FSM states; COMM covers both comm-port modes
  typedef enum logic [1:0] {
    S_COMM = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } arb_state_t;

  // Direct decode of the status input into the FSM state
  function automatic arb_state_t status_to_state(input logic [1:0] st);
    arb_state_t s;
    case (st)
      ST_RUN:  s = S_RUN;
      ST_HALT: s = S_HALT;
      default: s = S_COMM;
    endcase
    return s;
  endfunction

endpackage : mc_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : rr_arbiter                                               |
// | Purpose   : Combinational request picker. Round-robin from i_ptr by  |
// |             default; with MC_ARB_FIXED_PRIORITY_EN defined the       |
// |             lowest requesting index wins and there is no pointer.    |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module rr_arbiter
  import mc_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int PW        = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] i_req,
`ifndef MC_ARB_FIXED_PRIORITY_EN
  input  logic [PW-1:0]        i_ptr,
`endif
  output logic [NUM_CORES-1:0] o_grant,
  output logic [PW-1:0]        o_idx,
  output logic                 o_valid
);

`ifdef MC_ARB_FIXED_PRIORITY_EN

  // Lowest requesting index wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!o_valid && i_req[k]) begin
        o_valid    = 1'b1;
        o_idx      = PW'(k);
        o_grant[k] = 1'b1;
      end
    end
  end

`else

  // Candidate index ptr+k reduced modulo NUM_CORES (one spare bit for the sum)
  logic [PW:0] w_cand;

  // First requester at or after i_ptr, wrapping around
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_cand = (PW+1)'(i_ptr) + (PW+1)'(k);
      if (w_cand >= (PW+1)'(NUM_CORES)) begin
        w_cand = w_cand - (PW+1)'(NUM_CORES);
      end
      if (!o_valid && i_req[w_cand[PW-1:0]]) begin
        o_valid                  = 1'b1;
        o_idx                    = w_cand[PW-1:0];
        o_grant[w_cand[PW-1:0]]  = 1'b1;
      end
    end
  end

`endif

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mc_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : mc_mem_arbiter                                           |
// | Purpose   : Shares one single-port data memory between the comm      |
// |             port and NUM_CORES cores with a registered, pipelined    |
// |             grant (one access per cycle), and aggregates the cores'  |
// |             end-of-process flags.                                    |
// | Options   : MC_ARB_FIXED_PRIORITY_EN - fixed lowest-index priority   |
// |             instead of round-robin (no rotation pointer).            |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module mc_mem_arbiter
  import mc_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  status,
  input  logic [DATA_W-1:0]           com_data_in,
  input  logic [ADDR_W-1:0]           com_addr,
  input  logic                        com_wr_en,
  output logic [DATA_W-1:0]           com_data_out,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_wr_en,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_done,
  output logic [NUM_CORES-1:0]        core_grant,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           DM_addr,
  output logic [DATA_W-1:0]           DM_data_in,
  output logic                        DM_write_en,
  input  logic [DATA_W-1:0]           DM_out,
  output logic                        end_process
);

  localparam int PW = $clog2(NUM_CORES);

  arb_state_t            r_state;
  logic [ADDR_W-1:0]     r_dm_addr;
  logic [DATA_W-1:0]     r_dm_data;
  logic                  r_dm_we;
  logic [NUM_CORES-1:0]  r_grant;
  logic [NUM_CORES-1:0]  r_rvalid;
  logic                  r_end;
  logic [PW-1:0]         r_tag;
  logic                  r_tag_vld;

  logic [NUM_CORES-1:0]  w_eligible;
  logic [NUM_CORES-1:0]  w_win_onehot;
  logic [PW-1:0]         w_win_idx;
  logic                  w_win_valid;
  logic [ADDR_W-1:0]     w_win_addr;
  logic [DATA_W-1:0]     w_win_data;
  logic                  w_win_we;
  logic                  w_grant_ok;

  // A core granted this cycle still holds req, so it is masked out
  assign w_eligible = core_req & ~r_grant;

`ifndef MC_ARB_FIXED_PRIORITY_EN
  logic [PW-1:0]         r_rr_ptr;
`endif

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .PW        (PW)
  ) u_rr_arbiter (
    .i_req   (w_eligible),
`ifndef MC_ARB_FIXED_PRIORITY_EN
    .i_ptr   (r_rr_ptr),
`endif
    .o_grant (w_win_onehot),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  assign w_win_addr = core_addr[w_win_idx*ADDR_W +: ADDR_W];
  assign w_win_data = core_wdata[w_win_idx*DATA_W +: DATA_W];
  assign w_win_we   = core_wr_en[w_win_idx];

  // New grants only while both the registered state and the live status say RUN,
  // so a mid-run status change stops issuing immediately
  assign w_grant_ok = (r_state == S_RUN) && (status == ST_RUN) && w_win_valid;

  // FSM, DRAM port registers, grant/rvalid pipeline and done aggregation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_COMM;
      r_dm_addr <= '0;
      r_dm_data <= '0;
      r_dm_we   <= 1'b0;
      r_grant   <= '0;
      r_rvalid  <= '0;
      r_end     <= 1'b0;
      r_tag     <= '0;
      r_tag_vld <= 1'b0;
`ifndef MC_ARB_FIXED_PRIORITY_EN
      r_rr_ptr  <= '0;
`endif
    end else begin
      r_state <= status_to_state(status);

      // Read return: the access registered last cycle completes regardless of mode
      r_rvalid  <= r_tag_vld ? (NUM_CORES'(1) << r_tag) : '0;
      r_tag_vld <= 1'b0;
      r_grant   <= '0;

      // Sticky while in RUN, dropped as soon as status leaves RUN
      r_end <= (status == ST_RUN) && (r_end || (&core_done));

`ifndef MC_ARB_FIXED_PRIORITY_EN
      if ((r_state != S_RUN) && (status == ST_RUN)) begin
        r_rr_ptr <= '0;
      end
`endif

      case (r_state)
        S_COMM: begin
          r_dm_addr <= com_addr;
          r_dm_data <= com_data_in;
          r_dm_we   <= (status == ST_LOAD) && com_wr_en;
        end
        S_RUN: begin
          if (w_grant_ok) begin
            r_dm_addr <= w_win_addr;
            r_dm_data <= w_win_data;
            r_dm_we   <= w_win_we;
            r_grant   <= w_win_onehot;
            r_tag     <= w_win_idx;
            r_tag_vld <= ~w_win_we;
`ifndef MC_ARB_FIXED_PRIORITY_EN
            r_rr_ptr  <= (w_win_idx == PW'(NUM_CORES-1)) ? '0 : w_win_idx + 1'b1;
`endif
          end else begin
            r_dm_we <= 1'b0;
          end
        end
        default: begin
          r_dm_we <= 1'b0;
        end
      endcase
    end
  end

  assign DM_addr      = r_dm_addr;
  assign DM_data_in   = r_dm_data;
  assign DM_write_en  = r_dm_we;
  assign core_grant   = r_grant;
  assign core_rvalid  = r_rvalid;
  assign end_process  = r_end;
  assign core_rdata   = DM_out;
  assign com_data_out = DM_out;

endmodule : mc_mem_arbiter
`default_nettype wire

// File: tb/tb_mc_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_mc_mem_arbiter                                        |
// | Purpose   : Directed self-checking bench for mc_mem_arbiter with a   |
// |             behavioural one-cycle registered-read DRAM.              |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_mc_mem_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 16;

  logic            clk;
  logic            rst;
  logic [1:0]      status;
  logic [DW-1:0]   com_data_in;
  logic [AW-1:0]   com_addr;
  logic            com_wr_en;
  logic [DW-1:0]   com_data_out;
  logic [N-1:0]    core_req;
  logic [N-1:0]    core_wr_en;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [N-1:0]    core_done;
  logic [N-1:0]    core_grant;
  logic [N-1:0]    core_rvalid;
  logic [DW-1:0]   core_rdata;
  logic [AW-1:0]   DM_addr;
  logic [DW-1:0]   DM_data_in;
  logic            DM_write_en;
  logic [DW-1:0]   DM_out;
  logic            end_process;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  mc_mem_arbiter #(
    .NUM_CORES (N),
    .DATA_W    (DW),
    .ADDR_W    (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .status       (status),
    .com_data_in  (com_data_in),
    .com_addr     (com_addr),
    .com_wr_en    (com_wr_en),
    .com_data_out (com_data_out),
    .core_req     (core_req),
    .core_wr_en   (core_wr_en),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_done    (core_done),
    .core_grant   (core_grant),
    .core_rvalid  (core_rvalid),
    .core_rdata   (core_rdata),
    .DM_addr      (DM_addr),
    .DM_data_in   (DM_data_in),
    .DM_write_en  (DM_write_en),
    .DM_out       (DM_out),
    .end_process  (end_process)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port DRAM: write and registered read at the same edge
  always @(posedge clk) begin
    if (DM_write_en) mem[DM_addr] <= DM_data_in;
    DM_out <= mem[DM_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_DM_addr"},    32'(DM_addr),     32'h0);
    chk({tag, "_DM_data_in"}, 32'(DM_data_in),  32'h0);
    chk({tag, "_DM_we"},      32'(DM_write_en), 32'h0);
    chk({tag, "_grant"},      32'(core_grant),  32'h0);
    chk({tag, "_rvalid"},     32'(core_rvalid), 32'h0);
    chk({tag, "_end"},        32'(end_process), 32'h0);
  endtask

  logic [3:0] exp_g [0:4];
  logic [3:0] exp_r [0:4];

  initial begin
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    exp_r[0] = 4'b0000; exp_r[1] = 4'b0001; exp_r[2] = 4'b0010; exp_r[3] = 4'b0100; exp_r[4] = 4'b1000;

    rst         = 1'b1;
    status      = 2'b00;
    com_data_in = '0;
    com_addr    = '0;
    com_wr_en   = 1'b0;
    core_req    = '0;
    core_wr_en  = '0;
    core_addr   = '0;
    core_wdata  = '0;
    core_done   = '0;
    DM_out      = '0;

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // LOAD: comm write A5A5 @0x0010
    com_addr    = 16'h0010;
    com_data_in = 16'hA5A5;
    com_wr_en   = 1'b1;
    tick();
    chk("load_addr", 32'(DM_addr),     32'h0010);
    chk("load_data", 32'(DM_data_in),  32'hA5A5);
    chk("load_we",   32'(DM_write_en), 32'h1);

    // READBACK @0x0010: data two edges after the address is sampled
    com_wr_en = 1'b0;
    status    = 2'b10;
    tick();
    chk("rb_we_off", 32'(DM_write_en), 32'h0);
    tick();
    chk("rb_data",   32'(com_data_out), 32'hA5A5);

    // Enter RUN, then all four cores request reads continuously
    status = 2'b01;
    tick();
    chk("run_entry_grant", 32'(core_grant), 32'h0);
    for (int i = 0; i < N; i++) core_addr[i*AW +: AW] = 16'h0100 + 16'(i);
    core_req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk($sformatf("rr_grant_%0d", s),  32'(core_grant),  32'(exp_g[s]));
      chk($sformatf("rr_rvalid_%0d", s), 32'(core_rvalid), 32'(exp_r[s]));
      if (s == 0) chk("rr_addr_core0", 32'(DM_addr), 32'h0100);
    end
    core_req = '0;
    tick();
    chk("rr_tail_grant",  32'(core_grant),  32'h0);
    chk("rr_tail_rvalid", 32'(core_rvalid), 32'b0001);
    tick();
    chk("rr_idle_rvalid", 32'(core_rvalid), 32'h0);

    // Core 2 writes 0x1234 @0x0040, core 0 reads it back
    core_addr[2*AW +: AW]  = 16'h0040;
    core_wdata[2*DW +: DW] = 16'h1234;
    core_wr_en = 4'b0100;
    core_req   = 4'b0100;
    tick();
    chk("wr_grant", 32'(core_grant),  32'b0100);
    chk("wr_addr",  32'(DM_addr),     32'h0040);
    chk("wr_data",  32'(DM_data_in),  32'h1234);
    chk("wr_we",    32'(DM_write_en), 32'h1);
    core_wr_en = '0;
    core_addr[0*AW +: AW] = 16'h0040;
    core_req   = 4'b0001;
    tick();
    chk("rd_grant", 32'(core_grant),  32'b0001);
    chk("rd_we",    32'(DM_write_en), 32'h0);
    core_req = '0;
    tick();
    chk("rd_rvalid", 32'(core_rvalid), 32'b0001);
    chk("rd_rdata",  32'(core_rdata),  32'h1234);

    // Core 1 granted, then RUN -> HALT: rvalid still fires, no new grants
    core_req = 4'b0010;
    tick();
    chk("halt_pre_grant", 32'(core_grant), 32'b0010);
    status   = 2'b11;
    core_req = 4'b1101;
    tick();
    chk("halt_rvalid", 32'(core_rvalid), 32'b0010);
    chk("halt_grant0", 32'(core_grant),  32'h0);
    tick();
    chk("halt_grant1", 32'(core_grant),  32'h0);
    chk("halt_we",     32'(DM_write_en), 32'h0);
    chk("halt_rv_off", 32'(core_rvalid), 32'h0);

    // Re-enter RUN: pointer restarts at 0 so core 1 beats core 3
    status   = 2'b01;
    core_req = 4'b1010;
    tick();
    chk("reent_grant0", 32'(core_grant), 32'h0);
    tick();
    chk("reent_grant1", 32'(core_grant), 32'b0010);
    core_req = 4'b1000;
    tick();
    chk("reent_grant3", 32'(core_grant), 32'b1000);
    core_req = '0;
    tick();
    chk("reent_rvalid3", 32'(core_rvalid), 32'b1000);

    // end_process: done bits arrive one at a time
    core_done = 4'b0001;
    tick();
    chk("done_1", 32'(end_process), 32'h0);
    core_done = 4'b0011;
    tick();
    chk("done_2", 32'(end_process), 32'h0);
    core_done = 4'b0111;
    tick();
    chk("done_3", 32'(end_process), 32'h0);
    core_done = 4'b1111;
    tick();
    chk("done_4", 32'(end_process), 32'h1);
    core_done = 4'b0110;
    tick();
    chk("done_sticky", 32'(end_process), 32'h1);
    status = 2'b00;
    tick();
    chk("done_clear", 32'(end_process), 32'h0);
    core_done = '0;

    // Reset mid-RUN with a read pending
    status = 2'b01;
    tick();
    core_req = 4'b0001;
    tick();
    chk("rst_pre_grant", 32'(core_grant), 32'b0001);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    core_req = '0;
    rst      = 1'b0;
    tick();
    chk("post_rst_rvalid0", 32'(core_rvalid), 32'h0);
    chk("post_rst_grant",   32'(core_grant),  32'h0);
    tick();
    chk("post_rst_rvalid1", 32'(core_rvalid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_mc_mem_arbiter
`default_nettype wire
